tag_lookup_ctrl_l2: RTL and testbench

TAG_LOOKUP_CTRL_L2 -- requirements
Module: tag_lookup_ctrl_l2

---
 rtl/tag_lookup_ctrl_l2.sv | 143 ++++++++++++++
 tb/tb_tag_lookup_ctrl_l2.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_ctrl_l2.sv
// L2 tag lookup controller: sequences one tag-memory lookup per request, fills
// misses into a round-robin victim way and reports hit/miss with saturating stats.
`ifndef BW_WORD_ADDR
`define BW_WORD_ADDR 16
`endif
`ifndef BW_BLOCK
`define BW_BLOCK 2
`endif

module tag_lookup_ctrl_l2 #(
    parameter int CACHE_BLOCK_CAPACITY = 128,
    parameter int CACHE_SET_SIZE       = 4,
    localparam int BW_GRP = $clog2(CACHE_SET_SIZE),
    localparam int BW_ADD = $clog2(CACHE_BLOCK_CAPACITY),
    localparam int BW_SET = BW_ADD - BW_GRP,
    localparam int BW_TAG = `BW_WORD_ADDR - BW_SET - `BW_BLOCK,
    localparam int SW     = (BW_SET > 0) ? BW_SET : 1
) (
    input  logic                     clock_i,
    input  logic                     resetn_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [`BW_WORD_ADDR-1:0] req_addr_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic                     rsp_hit_o,
    output logic [BW_ADD-1:0]        rsp_add_o,
    output logic                     rsp_evict_o,
    output logic [BW_TAG-1:0]        rsp_evict_tag_o,
    output logic [SW-1:0]            tm_set_o,
    output logic [BW_TAG-1:0]        tm_tag_o,
    output logic [BW_ADD-1:0]        tm_add_o,
    output logic                     tm_wren_o,
    input  logic                     tm_hit_i,
    input  logic [BW_ADD-1:0]        tm_add_i,
    input  logic [BW_TAG-1:0]        tm_tag_i,
    output logic [31:0]              hit_count_o,
    output logic [31:0]              miss_count_o
);

    localparam int NUM_SETS = CACHE_BLOCK_CAPACITY / CACHE_SET_SIZE;

    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, FILL, RESP} state_t;

    state_t                    state_q;
    logic [BW_TAG-1:0]         tag_q;
    logic [SW-1:0]             set_q;
    logic [BW_TAG-1:0]         addr_tag;
    logic [SW-1:0]             addr_set;
    logic [CACHE_BLOCK_CAPACITY-1:0] valid_q;
    logic [BW_GRP-1:0]         ptr_q [NUM_SETS];
    logic [BW_GRP-1:0]         victim_way;
    logic                      unused_blk_bits;

    assign addr_tag        = req_addr_i[`BW_WORD_ADDR-1 -: BW_TAG];
    assign unused_blk_bits = ^req_addr_i[`BW_BLOCK-1:0];
    assign victim_way      = ptr_q[set_q];

    generate
        if (BW_SET > 0) begin : g_set
            assign addr_set = req_addr_i[BW_SET+`BW_BLOCK-1 : `BW_BLOCK];
            assign tm_add_o = {victim_way, set_q};
        end else begin : g_noset
            assign addr_set = '0;
            assign tm_add_o = victim_way;
        end
    endgenerate

    // In IDLE the incoming address is presented so the memory sees it early;
    // from LOOKUP onwards the captured request is held.
    assign tm_set_o = (state_q == IDLE) ? addr_set : set_q;
    assign tm_tag_o = (state_q == IDLE) ? addr_tag : tag_q;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q         <= IDLE;
            req_ready_o     <= 1'b0;
            tag_q           <= '0;
            set_q           <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_hit_o       <= 1'b0;
            rsp_add_o       <= '0;
            rsp_evict_o     <= 1'b0;
            rsp_evict_tag_o <= '0;
            tm_wren_o       <= 1'b0;
            valid_q         <= '0;
            hit_count_o     <= '0;
            miss_count_o    <= '0;
            for (int unsigned i = 0; i < NUM_SETS; i++) ptr_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        tag_q       <= addr_tag;
                        set_q       <= addr_set;
                        req_ready_o <= 1'b0;
                        state_q     <= LOOKUP;
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end
                LOOKUP: state_q <= CHECK;
                CHECK: begin
                    if (tm_hit_i) begin
                        rsp_hit_o   <= 1'b1;
                        rsp_add_o   <= tm_add_i;
                        rsp_evict_o <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        if (hit_count_o != '1) hit_count_o <= hit_count_o + 32'd1;
                        state_q     <= RESP;
                    end else begin
                        rsp_evict_tag_o <= tm_tag_i;
                        rsp_evict_o     <= valid_q[tm_add_o];
                        tm_wren_o       <= 1'b1;
                        if (miss_count_o != '1) miss_count_o <= miss_count_o + 32'd1;
                        state_q         <= FILL;
                    end
                end
                FILL: begin
                    tm_wren_o          <= 1'b0;
                    valid_q[tm_add_o]  <= 1'b1;
                    if (victim_way == BW_GRP'(CACHE_SET_SIZE - 1))
                        ptr_q[set_q] <= '0;
                    else
                        ptr_q[set_q] <= victim_way + BW_GRP'(1);
                    rsp_hit_o          <= 1'b0;
                    rsp_add_o          <= tm_add_o;
                    rsp_valid_o        <= 1'b1;
                    state_q            <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_lookup_ctrl_l2.sv
// Scoreboard bench for tag_lookup_ctrl_l2 with a behavioural tag memory.
module tb_tag_lookup_ctrl_l2;
    localparam int AW = 16, SETB = 5, WAYB = 2, TAGB = 9, ADDB = 7, NSET = 32, NWAY = 4;

    logic            clock_i = 1'b0;
    logic            resetn_i = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [AW-1:0]   req_addr_i = '0;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    logic            rsp_hit_o;
    logic [ADDB-1:0] rsp_add_o;
    logic            rsp_evict_o;
    logic [TAGB-1:0] rsp_evict_tag_o;
    logic [SETB-1:0] tm_set_o;
    logic [TAGB-1:0] tm_tag_o;
    logic [ADDB-1:0] tm_add_o;
    logic            tm_wren_o;
    logic            tm_hit_i;
    logic [ADDB-1:0] tm_add_i;
    logic [TAGB-1:0] tm_tag_i;
    logic [31:0]     hit_count_o;
    logic [31:0]     miss_count_o;

    always #5 clock_i = ~clock_i;

    tag_lookup_ctrl_l2 #(.CACHE_BLOCK_CAPACITY(128), .CACHE_SET_SIZE(4)) dut (
        .clock_i(clock_i), .resetn_i(resetn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
        .rsp_add_o(rsp_add_o), .rsp_evict_o(rsp_evict_o), .rsp_evict_tag_o(rsp_evict_tag_o),
        .tm_set_o(tm_set_o), .tm_tag_o(tm_tag_o), .tm_add_o(tm_add_o), .tm_wren_o(tm_wren_o),
        .tm_hit_i(tm_hit_i), .tm_add_i(tm_add_i), .tm_tag_i(tm_tag_i),
        .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    // Tag memory: registered hit search, combinational tag read, reset with the DUT.
    logic [TAGB-1:0] mem_tag [128];
    logic [127:0]    mem_val;
    logic [ADDB-1:0] mem_a;
    assign tm_tag_i = mem_tag[tm_add_o];

    always @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            mem_val  <= '0;
            tm_hit_i <= 1'b0;
            tm_add_i <= '0;
            for (int i = 0; i < 128; i++) mem_tag[i] <= '0;
        end else begin
            if (tm_wren_o) begin
                mem_tag[tm_add_o] <= tm_tag_o;
                mem_val[tm_add_o] <= 1'b1;
            end
            tm_hit_i <= 1'b0;
            tm_add_i <= '0;
            for (int w = 0; w < NWAY; w++) begin
                mem_a = {2'(w), tm_set_o};
                if (mem_val[mem_a] && mem_tag[mem_a] == tm_tag_o) begin
                    tm_hit_i <= 1'b1;
                    tm_add_i <= mem_a;
                end
            end
        end
    end

    int              wren_cnt = 0;
    logic [ADDB-1:0] wren_add = '0;
    always @(posedge clock_i) begin
        if (resetn_i && tm_wren_o) begin
            wren_cnt++;
            wren_add = tm_add_o;
        end
    end

    // Reference model of the controller's expected responses.
    typedef struct {
        logic            hit;
        logic [ADDB-1:0] add;
        logic            ev;
        logic [TAGB-1:0] evtag;
    } rsp_t;

    rsp_t            sb[$];
    logic [TAGB-1:0] m_tag [128];
    logic [127:0]    m_val;
    logic [WAYB-1:0] m_ptr [NSET];
    int              exp_hits, exp_miss;
    int              n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic model_reset();
        m_val = '0;
        for (int i = 0; i < 128; i++) m_tag[i] = '0;
        for (int i = 0; i < NSET; i++) m_ptr[i] = '0;
        exp_hits = 0;
        exp_miss = 0;
        sb.delete();
    endtask

    task automatic push_expect(input logic [TAGB-1:0] tag, input logic [SETB-1:0] set);
        rsp_t e;
        logic [ADDB-1:0] a;
        e.hit = 1'b0; e.add = '0; e.ev = 1'b0; e.evtag = '0;
        for (int w = 0; w < NWAY; w++) begin
            a = {2'(w), set};
            if (m_val[a] && m_tag[a] == tag) begin
                e.hit = 1'b1;
                e.add = a;
            end
        end
        if (e.hit) exp_hits++;
        else begin
            a = {m_ptr[set], set};
            e.add = a;
            e.ev = m_val[a];
            e.evtag = m_tag[a];
            m_val[a] = 1'b1;
            m_tag[a] = tag;
            m_ptr[set] = m_ptr[set] + 2'd1;
            exp_miss++;
        end
        sb.push_back(e);
    endtask

    task automatic do_req(input logic [TAGB-1:0] tag, input logic [SETB-1:0] set, input int hold);
        rsp_t e;
        int lat, w0;
        push_expect(tag, set);
        w0 = wren_cnt;
        @(negedge clock_i);
        lat = 0;
        while (!req_ready_o && lat < 20) begin @(negedge clock_i); lat++; end
        check("req_ready_wait", req_ready_o, 1);
        req_addr_i  = {tag, set, 2'($urandom)};
        req_valid_i = 1'b1;
        @(posedge clock_i); #1;
        req_valid_i = 1'b0;
        req_addr_i  = 16'($urandom);
        lat = 0;
        while (!rsp_valid_o && lat < 10) begin @(posedge clock_i); #1; lat++; end
        e = sb.pop_front();
        check("latency", lat, e.hit ? 2 : 3);
        check("rsp_hit", rsp_hit_o, e.hit);
        check("rsp_add", rsp_add_o, e.add);
        check("rsp_evict", rsp_evict_o, e.ev);
        if (e.ev) check("rsp_evict_tag", rsp_evict_tag_o, e.evtag);
        check("wren_pulses", wren_cnt - w0, e.hit ? 0 : 1);
        if (!e.hit) check("wren_add", wren_add, e.add);
        for (int i = 0; i < hold; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = 16'($urandom);
            @(posedge clock_i); #1;
            check("hold_valid", rsp_valid_o, 1);
            check("hold_hit", rsp_hit_o, e.hit);
            check("hold_add", rsp_add_o, e.add);
            check("hold_evict", rsp_evict_o, e.ev);
            check("hold_ready", req_ready_o, 0);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clock_i); #1;
        rsp_ready_i = 1'b0;
        check("rsp_drop", rsp_valid_o, 0);
        check("ready_back", req_ready_o, 1);
        if (hold > 0) begin
            repeat (3) @(posedge clock_i);
            #1;
            check("no_stray_rsp", rsp_valid_o, 0);
            check("no_stray_ready", req_ready_o, 1);
            check("no_stray_wren", wren_cnt - w0, e.hit ? 0 : 1);
        end
        check("hit_count", hit_count_o, exp_hits);
        check("miss_count", miss_count_o, exp_miss);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        check("rst_ready", req_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_wren", tm_wren_o, 0);
        check("rst_hits", hit_count_o, 0);
        check("rst_miss", miss_count_o, 0);
        @(negedge clock_i);
        resetn_i = 1'b1;
        @(posedge clock_i); #1;
        check("ready_after_rst", req_ready_o, 1);

        do_req(9'h12, 5'd3, 0);
        do_req(9'h12, 5'd3, 0);
        do_req(9'h13, 5'd3, 0);
        do_req(9'h14, 5'd3, 0);
        do_req(9'h15, 5'd3, 0);
        do_req(9'h16, 5'd3, 0);
        do_req(9'h14, 5'd3, 0);
        do_req(9'h1ab, 5'd7, 5);
        do_req(9'h1ab, 5'd7, 5);
        do_req(9'h000, 5'd31, 0);
        do_req(9'h1ff, 5'd0, 0);
        for (int i = 0; i < 14; i++)
            do_req(9'h020 + 9'($urandom_range(0, 4)), 5'($urandom_range(0, 1)), $urandom_range(0, 2));

        // Reset asserted while the fill write is in flight.
        @(negedge clock_i);
        req_addr_i  = {9'h055, 5'd3, 2'b00};
        req_valid_i = 1'b1;
        @(posedge clock_i); #1;
        req_valid_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #1;
        check("fill_wren", tm_wren_o, 1);
        #2 resetn_i = 1'b0;
        #1;
        check("abort_wren", tm_wren_o, 0);
        check("abort_hits", hit_count_o, 0);
        check("abort_miss", miss_count_o, 0);
        check("abort_rsp_valid", rsp_valid_o, 0);
        check("abort_ready", req_ready_o, 0);
        @(negedge clock_i);
        resetn_i = 1'b1;
        model_reset();
        @(posedge clock_i); #1;
        check("ready_after_abort", req_ready_o, 1);
        do_req(9'h12, 5'd3, 0);
        check("post_abort_add", rsp_add_o, 7'h03);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
